// File: rtl/reset_sequencer.sv
// Purpose: power-on reset sequencer: holds the PLL in reset, waits for a filtered lock,
//          then releases reset domains one at a time (bit 0 first) and reports RUN.
// Latency: every output is registered; a lock drop seen at PLL_LOCKED reaches the outputs 3 clocks later.
// Backpressure: none; this is a free-running control block with no handshaked interfaces.
//
// Ports:
//   EXT_CLK_50MHz  - single clock
//   ARESET         - asynchronous active-high reset; forces the PLL_HOLD values at once
//   PLL_LOCKED     - PLL lock status, asynchronous, synchronised internally (2 flops)
//   SW_RESET_REQ   - synchronous request for a full re-sequence, highest priority
//   PLL_ARESET     - active-high PLL reset, high only in PLL_HOLD
//   DOMAIN_RESET   - active-high per-domain resets, released in ascending bit order
//   SEQ_DONE       - high only in RUN
//   LOCK_LOSS_CNT  - saturating count of lock losses in RELEASE/RUN
// Optional feature: define RSTSEQ_LOCK_LOSS_CNT_EN to build the lock-loss counter;
// without it LOCK_LOSS_CNT is tied to 0.
module reset_sequencer #(
    parameter int NUM_DOMAINS         = 3,
    parameter int PLL_HOLD_CYCLES     = 127,
    parameter int LOCK_FILTER_CYCLES  = 8,
    parameter int LOCK_TIMEOUT_CYCLES = 4096,
    parameter int STAGE_DELAY_CYCLES  = 16
) (
    input  logic                   EXT_CLK_50MHz,
    input  logic                   ARESET,
    input  logic                   PLL_LOCKED,
    input  logic                   SW_RESET_REQ,
    output logic                   PLL_ARESET,
    output logic [NUM_DOMAINS-1:0] DOMAIN_RESET,
    output logic                   SEQ_DONE,
    output logic [7:0]             LOCK_LOSS_CNT
);

    localparam int HOLD_W = $clog2(PLL_HOLD_CYCLES + 1);
    localparam int FILT_W = $clog2(LOCK_FILTER_CYCLES + 1);
    localparam int TMO_W  = $clog2(LOCK_TIMEOUT_CYCLES + 1);
    localparam int STG_W  = $clog2(NUM_DOMAINS * STAGE_DELAY_CYCLES + 1);

    // Each counter leaves its state on the edge where it would reach its limit,
    // so the state lasts exactly that many clocks.
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(PLL_HOLD_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [STG_W-1:0]  STG_LAST  = STG_W'(NUM_DOMAINS * STAGE_DELAY_CYCLES - 1);
    localparam logic [FILT_W-1:0] FILT_FULL = FILT_W'(LOCK_FILTER_CYCLES);

    typedef enum logic [1:0] {
        ST_PLL_HOLD  = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_RELEASE   = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    state_t                   state, state_nxt;
    logic                     lock_meta, lock_s;
    logic [FILT_W-1:0]        filt_cnt;
    logic                     lock_ok;
    logic [HOLD_W-1:0]        hold_cnt, hold_nxt;
    logic [TMO_W-1:0]         tmo_cnt, tmo_nxt;
    logic [STG_W-1:0]         stage_cnt, stage_nxt;
    logic                     pll_areset_nxt;
    logic                     seq_done_nxt;
    logic [NUM_DOMAINS-1:0]   dom_nxt;

    // Two-flop synchroniser for the asynchronous lock input.
    always_ff @(posedge EXT_CLK_50MHz or posedge ARESET) begin
        if (ARESET) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= PLL_LOCKED;
            lock_s    <= lock_meta;
        end
    end

    // Lock filter: counts consecutive synchronised-high clocks and saturates.
    // It is held at zero while the PLL is in reset, so every WAIT_LOCK visit
    // starts a fresh qualification of the lock.
    always_ff @(posedge EXT_CLK_50MHz or posedge ARESET) begin
        if (ARESET) begin
            filt_cnt <= '0;
        end else if (state == ST_PLL_HOLD || !lock_s) begin
            filt_cnt <= '0;
        end else if (filt_cnt != FILT_FULL) begin
            filt_cnt <= filt_cnt + FILT_W'(1);
        end
    end

    assign lock_ok = (filt_cnt == FILT_FULL);

    // Next-state logic. Counters default to zero so that every state entry
    // (including a software restart of PLL_HOLD) begins counting from 0.
    always_comb begin
        state_nxt = state;
        hold_nxt  = '0;
        tmo_nxt   = '0;
        stage_nxt = '0;
        if (SW_RESET_REQ) begin
            state_nxt = ST_PLL_HOLD;
        end else begin
            case (state)
                ST_PLL_HOLD: begin
                    if (hold_cnt == HOLD_LAST) state_nxt = ST_WAIT_LOCK;
                    else                       hold_nxt  = hold_cnt + HOLD_W'(1);
                end
                ST_WAIT_LOCK: begin
                    // A qualified lock beats a coincident timeout.
                    if (lock_ok)                  state_nxt = ST_RELEASE;
                    else if (tmo_cnt == TMO_LAST) state_nxt = ST_PLL_HOLD;
                    else                          tmo_nxt   = tmo_cnt + TMO_W'(1);
                end
                ST_RELEASE: begin
                    // Lock loss is acted on from the raw synchronised bit, not the filter.
                    if (!lock_s)                    state_nxt = ST_PLL_HOLD;
                    else if (stage_cnt == STG_LAST) state_nxt = ST_RUN;
                    else                            stage_nxt = stage_cnt + STG_W'(1);
                end
                ST_RUN: begin
                    if (!lock_s) state_nxt = ST_PLL_HOLD;
                end
                default: state_nxt = ST_PLL_HOLD;
            endcase
        end

        // Outputs are decoded from the next state so they change on the same
        // edge as the state itself.
        pll_areset_nxt = (state_nxt == ST_PLL_HOLD);
        seq_done_nxt   = (state_nxt == ST_RUN);
        dom_nxt        = '1;
        if (state_nxt == ST_RUN) begin
            dom_nxt = '0;
        end else if (state_nxt == ST_RELEASE) begin
            for (int i = 0; i < NUM_DOMAINS; i++) begin
                dom_nxt[i] = (stage_nxt < STG_W'((i + 1) * STAGE_DELAY_CYCLES));
            end
        end
    end

    always_ff @(posedge EXT_CLK_50MHz or posedge ARESET) begin
        if (ARESET) begin
            state        <= ST_PLL_HOLD;
            hold_cnt     <= '0;
            tmo_cnt      <= '0;
            stage_cnt    <= '0;
            PLL_ARESET   <= 1'b1;
            DOMAIN_RESET <= '1;
            SEQ_DONE     <= 1'b0;
        end else begin
            state        <= state_nxt;
            hold_cnt     <= hold_nxt;
            tmo_cnt      <= tmo_nxt;
            stage_cnt    <= stage_nxt;
            PLL_ARESET   <= pll_areset_nxt;
            DOMAIN_RESET <= dom_nxt;
            SEQ_DONE     <= seq_done_nxt;
        end
    end

`ifdef RSTSEQ_LOCK_LOSS_CNT_EN
    // A software restart has priority over lock loss and is not counted.
    logic lock_loss;
    assign lock_loss = !SW_RESET_REQ && !lock_s &&
                       (state == ST_RELEASE || state == ST_RUN);

    always_ff @(posedge EXT_CLK_50MHz or posedge ARESET) begin
        if (ARESET) begin
            LOCK_LOSS_CNT <= 8'd0;
        end else if (lock_loss && LOCK_LOSS_CNT != 8'hFF) begin
            LOCK_LOSS_CNT <= LOCK_LOSS_CNT + 8'd1;
        end
    end
`else
    assign LOCK_LOSS_CNT = 8'd0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Purpose: self-checking bench for reset_sequencer with a phase/elapsed-time reference model.
// Latency: outputs compared 1 time unit after every rising clock edge.
// Backpressure: not applicable.
module tb_reset_sequencer;

    localparam int ND   = 3;
    localparam int HOLD = 127;
    localparam int LF   = 8;
    localparam int TMO  = 4096;
    localparam int SD   = 16;

`ifdef RSTSEQ_LOCK_LOSS_CNT_EN
    localparam bit LLC_EN = 1'b1;
`else
    localparam bit LLC_EN = 1'b0;
`endif

    localparam int P_HOLD = 0;
    localparam int P_WAIT = 1;
    localparam int P_REL  = 2;
    localparam int P_RUN  = 3;

    logic          EXT_CLK_50MHz = 1'b0;
    logic          ARESET        = 1'b0;
    logic          PLL_LOCKED    = 1'b1;
    logic          SW_RESET_REQ  = 1'b0;
    logic          PLL_ARESET;
    logic [ND-1:0] DOMAIN_RESET;
    logic          SEQ_DONE;
    logic [7:0]    LOCK_LOSS_CNT;

    always #10 EXT_CLK_50MHz = ~EXT_CLK_50MHz;

    reset_sequencer #(
        .NUM_DOMAINS        (ND),
        .PLL_HOLD_CYCLES    (HOLD),
        .LOCK_FILTER_CYCLES (LF),
        .LOCK_TIMEOUT_CYCLES(TMO),
        .STAGE_DELAY_CYCLES (SD)
    ) dut (
        .EXT_CLK_50MHz(EXT_CLK_50MHz),
        .ARESET       (ARESET),
        .PLL_LOCKED   (PLL_LOCKED),
        .SW_RESET_REQ (SW_RESET_REQ),
        .PLL_ARESET   (PLL_ARESET),
        .DOMAIN_RESET (DOMAIN_RESET),
        .SEQ_DONE     (SEQ_DONE),
        .LOCK_LOSS_CNT(LOCK_LOSS_CNT)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: which phase we are in, how many clocks since entering it,
    // the last two PLL_LOCKED samples, the run of synchronised highs and the loss count.
    int   m_ph, m_t, m_run, m_llc;
    logic m_s1, m_s2;

    task automatic model_reset();
        m_ph = P_HOLD; m_t = 0; m_run = 0; m_llc = 0; m_s1 = 1'b0; m_s2 = 1'b0;
    endtask

    task automatic model_edge(input logic pll, input logic sw);
        int   ph0 = m_ph;
        logic ls  = m_s2;
        if (sw) begin
            m_ph = P_HOLD; m_t = 0;
        end else if (ph0 == P_HOLD) begin
            m_t++;
            if (m_t == HOLD) begin m_ph = P_WAIT; m_t = 0; end
        end else if (ph0 == P_WAIT) begin
            if (m_run >= LF) begin
                m_ph = P_REL; m_t = 0;
            end else begin
                m_t++;
                if (m_t == TMO) begin m_ph = P_HOLD; m_t = 0; end
            end
        end else if (!ls) begin
            m_ph = P_HOLD; m_t = 0;
            if (m_llc < 255) m_llc++;
        end else if (ph0 == P_REL) begin
            m_t++;
            if (m_t == ND * SD) begin m_ph = P_RUN; m_t = 0; end
        end
        // Qualification of the lock restarts whenever the PLL was held in reset.
        if (ph0 == P_HOLD) m_run = 0;
        else if (ls)       m_run++;
        else               m_run = 0;
        m_s2 = m_s1;
        m_s1 = pll;
    endtask

    function automatic logic [12:0] exp_vec();
        logic [ND-1:0] d;
        logic [7:0]    llc;
        for (int i = 0; i < ND; i++) begin
            if (m_ph == P_REL)      d[i] = (m_t < (i + 1) * SD);
            else if (m_ph == P_RUN) d[i] = 1'b0;
            else                    d[i] = 1'b1;
        end
        llc = LLC_EN ? 8'(m_llc) : 8'd0;
        return {m_ph == P_HOLD, d, m_ph == P_RUN, llc};
    endfunction

    function automatic logic [12:0] obs_vec();
        return {PLL_ARESET, DOMAIN_RESET, SEQ_DONE, LOCK_LOSS_CNT};
    endfunction

    task automatic tick();
        @(posedge EXT_CLK_50MHz);
        if (ARESET) model_reset();
        else        model_edge(PLL_LOCKED, SW_RESET_REQ);
        #1;
        chk("outputs", 32'(obs_vec()), 32'(exp_vec()));
    endtask

    // Asserts ARESET between edges and checks that the outputs respond at once.
    task automatic do_areset(input int cyc);
        ARESET = 1'b1;
        #1;
        model_reset();
        chk("areset_async", 32'(obs_vec()), 32'(exp_vec()));
        repeat (cyc) tick();
        ARESET = 1'b0;
    endtask

    task automatic wait_phase(input int ph, input string tag);
        int n = 0;
        while (m_ph != ph && n < 5000) begin tick(); n++; end
        if (m_ph != ph) chk({"timeout_", tag}, 32'(m_ph), 32'(ph));
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!SEQ_DONE && n < 400) begin tick(); n++; end
        chk(tag, 32'(SEQ_DONE), 32'd1);
    endtask

    // Number of clocks until PLL_ARESET leaves level lvl (the changing clock included).
    task automatic run_len(input logic lvl, input int cap, output int n);
        n = 0;
        do begin tick(); n++; end while (PLL_ARESET == lvl && n < cap);
    endtask

    initial begin
        int t_pa, t_d0, t_d1, t_d2, t_done, n, pg, len;
        logic saw;

        model_reset();
        #2;
        PLL_LOCKED = 1'b1;
        do_areset(3);

        // Normal power-up with a steady lock.
        t_pa = -1; t_d0 = -1; t_d1 = -1; t_d2 = -1; t_done = -1;
        for (int k = 1; k <= 400 && t_done < 0; k++) begin
            tick();
            if (t_pa < 0 && !PLL_ARESET)      t_pa = k;
            if (t_d0 < 0 && !DOMAIN_RESET[0]) t_d0 = k;
            if (t_d1 < 0 && !DOMAIN_RESET[1]) t_d1 = k;
            if (t_d2 < 0 && !DOMAIN_RESET[2]) t_d2 = k;
            if (t_done < 0 && SEQ_DONE)       t_done = k;
        end
        chk("pll_areset_fall", 32'(t_pa), 32'(HOLD));
        chk("dom0_after_pll", 32'(t_d0 - t_pa), 32'(LF + 1 + SD));
        chk("dom1_gap", 32'(t_d1 - t_d0), 32'(SD));
        chk("dom2_gap", 32'(t_d2 - t_d1), 32'(SD));
        chk("done_with_dom2", 32'(t_done), 32'(t_d2));

        // One-clock lock drop in RUN.
        repeat ($urandom_range(1, 20)) tick();
        PLL_LOCKED = 1'b0;
        n = 0;
        do begin
            tick(); n++;
            PLL_LOCKED = 1'b1;
        end while (!PLL_ARESET && n < 10);
        chk("lockloss_latency", 32'(n), 32'd3);
        chk("lockloss_dom", 32'(DOMAIN_RESET), 32'h7);
        chk("lockloss_done", 32'(SEQ_DONE), 32'd0);
        chk("lockloss_cnt", 32'(LOCK_LOSS_CNT), LLC_EN ? 32'd1 : 32'd0);
        wait_done("reseq_done");

        // Software restart while half-released.
        do_areset(2);
        n = 0;
        while (DOMAIN_RESET != 3'b110 && n < 400) begin tick(); n++; end
        chk("reach_110", 32'(DOMAIN_RESET), 32'h6);
        SW_RESET_REQ = 1'b1;
        tick();
        SW_RESET_REQ = 1'b0;
        chk("sw_dom", 32'(DOMAIN_RESET), 32'h7);
        chk("sw_pll_areset", 32'(PLL_ARESET), 32'd1);
        run_len(1'b1, 300, n);
        chk("sw_hold_len", 32'(n), 32'(HOLD));

        // Lock glitching low one clock in five never qualifies.
        do_areset(2);
        wait_phase(P_WAIT, "glitch_wait");
        saw = 1'b0;
        for (int k = 0; k < 300; k++) begin
            PLL_LOCKED = (k % 5 == 4) ? 1'b0 : 1'b1;
            tick();
            if (DOMAIN_RESET != 3'b111) saw = 1'b1;
        end
        chk("glitch_no_release", 32'(saw), 32'd0);

        // No lock at all: hold / timeout cycling.
        PLL_LOCKED = 1'b0;
        do_areset(2);
        run_len(1'b1, 300, n);
        chk("nolock_hold1", 32'(n), 32'(HOLD));
        run_len(1'b0, 5000, n);
        chk("nolock_wait", 32'(n), 32'(TMO));
        run_len(1'b1, 300, n);
        chk("nolock_hold2", 32'(n), 32'(HOLD));
        chk("nolock_dom", 32'(DOMAIN_RESET), 32'h7);

        // Randomised lock noise, software restarts and occasional async resets.
        PLL_LOCKED = 1'b1;
        for (int seg = 0; seg < 30; seg++) begin
            case ($urandom_range(0, 3))
                0:       pg = 0;
                1:       pg = 1;
                2:       pg = 15;
                default: pg = 50;
            endcase
            len = $urandom_range(200, 800);
            for (int c = 0; c < len; c++) begin
                PLL_LOCKED   = ($urandom_range(0, 99) >= pg);
                SW_RESET_REQ = ($urandom_range(0, 499) == 0);
                if ($urandom_range(0, 1999) == 0) begin
                    SW_RESET_REQ = 1'b0;
                    do_areset($urandom_range(1, 4));
                end else begin
                    tick();
                end
            end
        end
        SW_RESET_REQ = 1'b0;
        PLL_LOCKED   = 1'b1;

        // 300 lock losses during RELEASE saturate the counter.
        do_areset(2);
        for (int k = 0; k < 300; k++) begin
            wait_phase(P_REL, "loss_rel");
            PLL_LOCKED = 1'b0;
            tick();
            PLL_LOCKED = 1'b1;
            tick();
            tick();
        end
        chk("llc_saturate", 32'(LOCK_LOSS_CNT), LLC_EN ? 32'd255 : 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
